// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int MAX_DATA_BITS = 9;

  // Unused upper bits must be zero so they do not disturb the XOR.
  function automatic logic calcParity(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through FIFO: the head entry is visible on o_data whenever not empty.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_data,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic             w_popOk;
  logic             w_pushOk;

  // A push into a full FIFO is allowed only when a pop frees the slot in the same cycle.
  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == (AW+1)'(DEPTH));
  assign w_popOk  = i_pop && !o_empty;
  assign w_pushOk = i_push && (!o_full || w_popOk);
  assign o_data   = o_empty ? '0 : r_mem[r_rdPtr];
  assign o_count  = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_pushOk) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_popOk)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_pushOk, w_popOk})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_pushOk) r_mem[r_wrPtr] <= i_data;
  end

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// UART receiver with mid-bit sampling, optional parity, sticky error flags and a FWFT receive FIFO.
module uart_rx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 5208,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        RX,
  input  logic                        rd_en,
  input  logic                        clr_err,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        rdy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt,
  output logic                        frame_err,
  output logic                        parity_err,
  output logic                        overrun
);

  localparam int             CW        = $clog2(BAUD_DIV);
  localparam logic [CW-1:0]  BAUD_HALF = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0]  BAUD_FULL = CW'(BAUD_DIV - 1);
  localparam int             BW        = 4;
  localparam logic [BW-1:0]  LAST_BIT  = BW'(DATA_BITS - 1);

  uart_state_e          r_state, w_next;
  logic                 r_rxMeta, r_rxS;
  logic [CW-1:0]        r_baudCnt;
  logic [BW-1:0]        r_bitCnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parMis;
  logic                 r_frameErr, r_parityErr, r_overrun;
  logic                 w_sample, w_startDet, w_shiftEn, w_parSample, w_stopSample;
  logic                 w_good, w_full, w_empty;

  // Idle-high line: the synchroniser resets to 1 so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxMeta <= 1'b1;
      r_rxS    <= 1'b1;
    end else begin
      r_rxMeta <= RX;
      r_rxS    <= r_rxMeta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (!r_rxS) w_next = START;
      START:   if (w_sample) w_next = r_rxS ? IDLE : DATA;
      DATA:    if (w_sample && (r_bitCnt == LAST_BIT)) w_next = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (w_sample) w_next = STOP;
      STOP:    if (w_sample) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_startDet   = 1'b0;
    w_shiftEn    = 1'b0;
    w_parSample  = 1'b0;
    w_stopSample = 1'b0;
    case (r_state)
      IDLE:    w_startDet   = !r_rxS;
      DATA:    w_shiftEn    = w_sample;
      PARITY:  w_parSample  = w_sample;
      STOP:    w_stopSample = w_sample;
      default: ;
    endcase
  end

  assign w_sample = (r_state != IDLE) && (r_baudCnt == '0);
  assign w_good   = w_stopSample && r_rxS && !r_parMis;

  // Idle keeps the counter preloaded with a half bit so the first sample lands mid start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baudCnt <= BAUD_HALF;
      r_bitCnt  <= '0;
      r_shift   <= '0;
      r_parMis  <= 1'b0;
    end else begin
      if (r_state == IDLE)      r_baudCnt <= BAUD_HALF;
      else if (r_baudCnt == '0) r_baudCnt <= BAUD_FULL;
      else                      r_baudCnt <= r_baudCnt - 1'b1;
      if (w_startDet)     r_bitCnt <= '0;
      else if (w_shiftEn) r_bitCnt <= r_bitCnt + 1'b1;
      if (w_shiftEn) r_shift <= {r_rxS, r_shift[DATA_BITS-1:1]};
      if (w_startDet)       r_parMis <= 1'b0;
      else if (w_parSample) r_parMis <= r_rxS != calcParity(MAX_DATA_BITS'(r_shift), PARITY_ODD != 0);
    end
  end

  // Set events take priority over clr_err so no error can slip through in the clearing cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frameErr  <= 1'b0;
      r_parityErr <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_stopSample && !r_rxS) r_frameErr <= 1'b1;
      else if (clr_err)           r_frameErr <= 1'b0;
      if (w_stopSample && r_parMis) r_parityErr <= 1'b1;
      else if (clr_err)             r_parityErr <= 1'b0;
      if (w_good && w_full && !rd_en) r_overrun <= 1'b1;
      else if (clr_err)               r_overrun <= 1'b0;
    end
  end

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_good),
    .i_pop   (rd_en),
    .i_data  (r_shift),
    .o_data  (rx_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_cnt)
  );

  assign rdy        = !w_empty;
  assign frame_err  = r_frameErr;
  assign parity_err = r_parityErr;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Bench for uart_rx_fifo_ctrl: an 8N1 instance and an 8E1 instance checked against a queue-based frame model.
module tb_uart_rx_fifo_ctrl;

  localparam int BAUD = 16;

  logic       clk = 1'b0;
  logic       rst_n, clrErr;
  logic       rx0, rxP, rd0, rdP;
  logic [7:0] data0, dataP;
  logic [2:0] cnt0, cntP;
  logic       rdy0, rdyP, fe0, feP, pe0, peP, ov0, ovP;

  int         checks = 0;
  int         errors = 0;

  byte unsigned q0[$];
  byte unsigned q1[$];
  bit           mFe[2];
  bit           mPe[2];
  bit           mOv[2];

  always #5 clk = ~clk;

  uart_rx_fifo_ctrl #(.BAUD_DIV(BAUD), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .RX(rx0), .rd_en(rd0), .clr_err(clrErr),
    .rx_data(data0), .rdy(rdy0), .fifo_cnt(cnt0),
    .frame_err(fe0), .parity_err(pe0), .overrun(ov0)
  );

  uart_rx_fifo_ctrl #(.BAUD_DIV(BAUD), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .FIFO_DEPTH(4)) dutP (
    .clk(clk), .rst_n(rst_n), .RX(rxP), .rd_en(rdP), .clr_err(clrErr),
    .rx_data(dataP), .rdy(rdyP), .fifo_cnt(cntP),
    .frame_err(feP), .parity_err(peP), .overrun(ovP)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setRx(input int which, input logic v);
    if (which == 0) rx0 = v;
    else            rxP = v;
  endtask

  task automatic setRd(input int which, input logic v);
    if (which == 0) rd0 = v;
    else            rdP = v;
  endtask

  function automatic byte unsigned modelHead(input int which);
    if (which == 0) return (q0.size() != 0) ? q0[0] : 8'h00;
    return (q1.size() != 0) ? q1[0] : 8'h00;
  endfunction

  function automatic int modelSize(input int which);
    return (which == 0) ? q0.size() : q1.size();
  endfunction

  // Frame rules: bad stop -> frame error, even-parity mismatch -> parity error,
  // good frame is stored unless all 4 slots stay occupied (then overrun).
  task automatic modelFrame(input int which, input byte unsigned d, input bit parBit,
                            input bit stopBit, input bit popAtStop);
    byte unsigned q[$];
    bit mism;
    q = (which == 0) ? q0 : q1;
    mism = (which == 1) && ((^d) != parBit);
    if (!stopBit) mFe[which] = 1'b1;
    if (mism)     mPe[which] = 1'b1;
    if (popAtStop && q.size() != 0) void'(q.pop_front());
    if (stopBit && !mism) begin
      if (q.size() < 4) q.push_back(d);
      else              mOv[which] = 1'b1;
    end
    if (which == 0) q0 = q;
    else            q1 = q;
  endtask

  task automatic checkOutput(input int which, input string tag);
    int n;
    n = modelSize(which);
    if (which == 0) begin
      check({tag, ".cnt"},  32'(cnt0),  32'(n));
      check({tag, ".rdy"},  32'(rdy0),  32'(n != 0));
      check({tag, ".data"}, 32'(data0), 32'(modelHead(0)));
      check({tag, ".fe"},   32'(fe0),   32'(mFe[0]));
      check({tag, ".pe"},   32'(pe0),   32'(mPe[0]));
      check({tag, ".ov"},   32'(ov0),   32'(mOv[0]));
    end else begin
      check({tag, ".cntP"},  32'(cntP),  32'(n));
      check({tag, ".rdyP"},  32'(rdyP),  32'(n != 0));
      check({tag, ".dataP"}, 32'(dataP), 32'(modelHead(1)));
      check({tag, ".feP"},   32'(feP),   32'(mFe[1]));
      check({tag, ".peP"},   32'(peP),   32'(mPe[1]));
      check({tag, ".ovP"},   32'(ovP),   32'(mOv[1]));
    end
  endtask

  // Start bit at edge E0+1; stop-bit sample pulse falls in the cycle before edge
  // E0 + 3 + BAUD/2 + BAUD*(bits-1): 2 sync flops, 1 idle-detect cycle, then half/full bits.
  task automatic applyStimulus(input int which, input byte unsigned d, input bit parBit,
                               input bit stopBit, input bit popAtStop);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (which == 1) bits.push_back(parBit);
    bits.push_back(stopBit);
    @(posedge clk); #1;
    for (int i = 0; i < bits.size(); i++) begin
      setRx(which, bits[i]);
      if (i == bits.size() - 1 && popAtStop) begin
        repeat (BAUD / 2 + 2) @(posedge clk);
        #1 setRd(which, 1'b1);
        check("popAtStop.head", 32'(which == 0 ? data0 : dataP), 32'(modelHead(which)));
        @(posedge clk);
        #1 setRd(which, 1'b0);
        repeat (BAUD / 2 - 3) @(posedge clk);
        #1;
      end else begin
        repeat (BAUD) @(posedge clk);
        #1;
      end
    end
    setRx(which, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    modelFrame(which, d, parBit, stopBit, popAtStop);
  endtask

  task automatic readPop(input int which);
    setRd(which, 1'b1);
    @(posedge clk);
    #1 setRd(which, 1'b0);
    if (which == 0 && q0.size() != 0) void'(q0.pop_front());
    if (which == 1 && q1.size() != 0) void'(q1.pop_front());
  endtask

  task automatic clearErrors();
    clrErr = 1'b1;
    @(posedge clk);
    #1 clrErr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mFe[i] = 1'b0; mPe[i] = 1'b0; mOv[i] = 1'b0;
    end
  endtask

  task automatic modelReset();
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) begin
      mFe[i] = 1'b0; mPe[i] = 1'b0; mOv[i] = 1'b0;
    end
  endtask

  initial begin
    byte unsigned d;
    bit           pb, sb;
    int           w;
    rst_n = 1'b0; clrErr = 1'b0;
    rx0 = 1'b1; rxP = 1'b1; rd0 = 1'b0; rdP = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #1 checkOutput(0, "reset");
    checkOutput(1, "reset");
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] two 8N1 bytes, one read");
    applyStimulus(0, 8'hA5, 1'b0, 1'b1, 1'b0);
    applyStimulus(0, 8'h3C, 1'b0, 1'b1, 1'b0);
    check("twoBytes.head", 32'(data0), 32'h A5);
    checkOutput(0, "twoBytes");
    readPop(0);
    check("afterPop.head", 32'(data0), 32'h3C);
    checkOutput(0, "afterPop");
    readPop(0);
    readPop(0);
    checkOutput(0, "drainedEmptyPop");

    $display("[TB] false start");
    rx0 = 1'b0;
    repeat (5) @(posedge clk);
    #1 rx0 = 1'b1;
    repeat (40) @(posedge clk);
    #1 checkOutput(0, "falseStart");
    d = 8'($urandom);
    applyStimulus(0, d, 1'b0, 1'b1, 1'b0);
    checkOutput(0, "afterFalseStart");

    $display("[TB] framing error and clear");
    applyStimulus(0, 8'h55, 1'b0, 1'b0, 1'b0);
    check("frameErr.fe", 32'(fe0), 32'd1);
    checkOutput(0, "frameErr");
    clearErrors();
    checkOutput(0, "frameErrCleared");
    readPop(0);

    $display("[TB] even parity");
    applyStimulus(1, 8'h07, 1'b1, 1'b1, 1'b0);
    checkOutput(1, "parityGood");
    applyStimulus(1, 8'h07, 1'b0, 1'b1, 1'b0);
    check("parityBad.pe", 32'(peP), 32'd1);
    checkOutput(1, "parityBad");
    readPop(1);
    clearErrors();

    $display("[TB] overrun without reads");
    for (int i = 1; i <= 5; i++) applyStimulus(0, 8'(i), 1'b0, 1'b1, 1'b0);
    check("overrun.ov", 32'(ov0), 32'd1);
    checkOutput(0, "overrun");
    for (int i = 1; i <= 4; i++) begin
      check("overrunDrain", 32'(data0), 32'(i));
      readPop(0);
    end
    checkOutput(0, "overrunDrained");
    clearErrors();

    $display("[TB] full FIFO with read on stop sample");
    for (int i = 1; i <= 4; i++) applyStimulus(0, 8'(i), 1'b0, 1'b1, 1'b0);
    applyStimulus(0, 8'h05, 1'b0, 1'b1, 1'b1);
    check("pushPop.ov", 32'(ov0), 32'd0);
    checkOutput(0, "pushPop");
    for (int i = 2; i <= 5; i++) begin
      check("pushPopDrain", 32'(data0), 32'(i));
      readPop(0);
    end

    $display("[TB] random frames");
    for (int k = 0; k < 8; k++) begin
      w  = int'($urandom_range(0, 1));
      d  = 8'($urandom);
      pb = (^d) ^ ($urandom_range(0, 3) == 0);
      sb = ($urandom_range(0, 4) != 0);
      applyStimulus(w, d, pb, sb, 1'b0);
      checkOutput(w, "random");
      if ($urandom_range(0, 1) == 1) readPop(w);
      if ($urandom_range(0, 2) == 0) clearErrors();
    end

    $display("[TB] reset mid-frame");
    applyStimulus(1, 8'h5A, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rx0 = 1'b0;
    repeat (BAUD) @(posedge clk);
    #1 rx0 = 1'b1;
    repeat (BAUD + BAUD / 2) @(posedge clk);
    #1 rst_n = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1 checkOutput(0, "midReset");
    checkOutput(1, "midReset");
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    applyStimulus(0, 8'h81, 1'b0, 1'b1, 1'b0);
    check("afterReset.head", 32'(data0), 32'h81);
    checkOutput(0, "afterReset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
